// File: rtl/anim_pkg.sv
// Shared encodings for the segment-animation path: mode codes, pattern lengths
// and the step index width used by both the control stage and the pattern stage.
package anim_pkg;

  localparam int STEP_W = 5;
  localparam int LEN_A  = 20;
  localparam int LEN_B  = 8;
  localparam int LEN_C  = 12;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_A    = 2'd1,
    MODE_B    = 2'd2,
    MODE_C    = 2'd3
  } mode_e;

  // Last valid step index of a pattern; IDLE has a single step.
  function automatic logic [STEP_W-1:0] pat_last(mode_e m);
    case (m)
      MODE_A:  return STEP_W'(LEN_A - 1);
      MODE_B:  return STEP_W'(LEN_B - 1);
      MODE_C:  return STEP_W'(LEN_C - 1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-flop synchroniser (released level on reset) followed by a
// stability counter that flips the accepted level after DEB_CYC quiet cycles.
module btn_debounce #(
  parameter int DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_pressed
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             w_lvl;

  assign w_lvl     = ~r_sync[1];
  assign o_pressed = r_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      // Any sample matching the accepted level restarts the count.
      if (w_lvl == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/anim_step_ctrl.sv
// Animation control front end: debounced buttons, fixed-priority mode select
// and the step timebase driving the downstream pattern index.
module anim_step_ctrl
  import anim_pkg::*;
#(
  parameter int CLOCK_MHZ   = 50,
  parameter int US_PER_MS   = 1000,
  parameter int DEBOUNCE_MS = 10,
  parameter int STEP_MS     = 500
) (
  input  logic              clk,
  input  logic              swch1,
  input  logic              btn0,
  input  logic              btn1,
  input  logic              btn2,
  output logic [2:0]        btn_db,
  output logic [1:0]        mode,
  output logic [STEP_W-1:0] step,
  output logic              step_pulse
);

  localparam int MS_CYC   = CLOCK_MHZ * US_PER_MS;
  localparam int DEB_CYC  = DEBOUNCE_MS * MS_CYC;
  localparam int STEP_CYC = STEP_MS * MS_CYC;
  localparam int PH_W     = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(STEP_CYC - 1);

  logic [2:0]        w_btn_n;
  logic [2:0]        w_db;
  mode_e             r_mode, w_mode_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic              r_pulse, w_pulse_nxt;

  assign w_btn_n = {btn2, btn1, btn0};

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_db [2:0] (
    .clk       (clk),
    .rst       (swch1),
    .i_btn_n   (w_btn_n),
    .o_pressed (w_db)
  );

  always_ff @(posedge clk) begin
    if (swch1) begin
      r_mode  <= MODE_IDLE;
      r_phase <= '0;
      r_step  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_phase <= w_phase_nxt;
      r_step  <= w_step_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = MODE_IDLE;
    w_phase_nxt = '0;
    w_step_nxt  = '0;
    w_pulse_nxt = 1'b0;
    if      (w_db[0]) w_mode_nxt = MODE_A;
    else if (w_db[1]) w_mode_nxt = MODE_B;
    else if (w_db[2]) w_mode_nxt = MODE_C;
    // A mode change restarts the pattern; IDLE parks everything at zero.
    if (w_mode_nxt == r_mode && r_mode != MODE_IDLE) begin
      if (r_phase == PH_LAST) begin
        w_step_nxt  = (r_step == pat_last(r_mode)) ? '0 : r_step + STEP_W'(1);
        w_pulse_nxt = 1'b1;
      end else begin
        w_phase_nxt = r_phase + PH_W'(1);
        w_step_nxt  = r_step;
      end
    end
  end

  assign btn_db     = w_db;
  assign mode       = r_mode;
  assign step       = r_step;
  assign step_pulse = r_pulse;

endmodule

// File: tb/tb_anim_step_ctrl.sv
// Directed bench for anim_step_ctrl with shortened timebase (DEB_CYC=20, STEP_CYC=30).
module tb_anim_step_ctrl;

  logic       clk = 1'b0;
  logic       swch1;
  logic       btn0, btn1, btn2;
  logic [2:0] btn_db;
  logic [1:0] mode;
  logic [4:0] step;
  logic       step_pulse;

  int n_cmp = 0;
  int n_err = 0;

  anim_step_ctrl #(
    .CLOCK_MHZ(2), .US_PER_MS(5), .DEBOUNCE_MS(2), .STEP_MS(3)
  ) dut (
    .clk(clk), .swch1(swch1), .btn0(btn0), .btn1(btn1), .btn2(btn2),
    .btn_db(btn_db), .mode(mode), .step(step), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_db, input logic [1:0] e_mode,
                         input logic [4:0] e_step, input logic e_pulse);
    chk({tag, ".btn_db"}, 32'(btn_db), 32'(e_db));
    chk({tag, ".mode"},   32'(mode),   32'(e_mode));
    chk({tag, ".step"},   32'(step),   32'(e_step));
    chk({tag, ".pulse"},  32'(step_pulse), 32'(e_pulse));
  endtask

  initial begin
    swch1 = 1'b1; btn0 = 1'b1; btn1 = 1'b1; btn2 = 1'b1;

    // Reset
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_all("reset", 3'b000, 2'd0, 5'd0, 1'b0);
    end
    swch1 = 1'b0;
    tick(5);
    chk_all("idle_after_reset", 3'b000, 2'd0, 5'd0, 1'b0);

    // PAT_A: press latency, step run with wrap at 20
    btn0 = 1'b0;
    tick(21);
    chk("a_db_edge21", 32'(btn_db), 32'd0);
    tick(1);
    chk("a_db_edge22", 32'(btn_db), 32'd1);
    chk("a_mode_edge22", 32'(mode), 32'd0);
    tick(1);
    chk_all("a_mode_edge23", 3'b001, 2'd1, 5'd0, 1'b0);
    tick(29);
    chk("a_no_early_pulse", 32'(step_pulse), 32'd0);
    tick(1);
    chk("a_pulse1", 32'(step_pulse), 32'd1);
    chk("a_step1", 32'(step), 32'd1);
    tick(1);
    chk("a_pulse1_end", 32'(step_pulse), 32'd0);
    for (int k = 2; k <= 20; k++) begin
      tick(29);
      chk($sformatf("a_pulse%0d", k), 32'(step_pulse), 32'd1);
      chk($sformatf("a_step%0d", k), 32'(step), 32'(k % 20));
      tick(1);
      chk($sformatf("a_pulse%0d_end", k), 32'(step_pulse), 32'd0);
    end

    // Release latency back to IDLE
    btn0 = 1'b1;
    tick(21);
    chk("a_rel_db21", 32'(btn_db), 32'd1);
    tick(1);
    chk("a_rel_db22", 32'(btn_db), 32'd0);
    tick(1);
    chk_all("a_rel_idle", 3'b000, 2'd0, 5'd0, 1'b0);

    // Bounce rejection on btn1
    btn1 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("bounce_low", 32'(btn_db), 32'd0);
    end
    btn1 = 1'b1;
    tick(3);
    btn1 = 1'b0;
    for (int i = 0; i < 21; i++) begin
      tick(1);
      chk("bounce_hold", 32'(btn_db), 32'd0);
    end
    tick(1);
    chk("bounce_db_edge22", 32'(btn_db), 32'b010);
    tick(1);
    chk_all("b_mode", 3'b010, 2'd2, 5'd0, 1'b0);

    // Priority: btn0 pre-empts btn1 at step 5, then hands back
    tick(150);
    chk_all("b_step5", 3'b010, 2'd2, 5'd5, 1'b1);
    btn0 = 1'b0;
    tick(22);
    chk_all("prio_db_both", 3'b011, 2'd2, 5'd5, 1'b0);
    tick(1);
    chk_all("prio_to_a", 3'b011, 2'd1, 5'd0, 1'b0);
    tick(29);
    chk("prio_a_nopulse", 32'(step_pulse), 32'd0);
    tick(1);
    chk_all("prio_a_pulse", 3'b011, 2'd1, 5'd1, 1'b1);
    btn0 = 1'b1;
    tick(22);
    chk_all("handback_db", 3'b010, 2'd1, 5'd1, 1'b0);
    tick(1);
    chk_all("handback_b", 3'b010, 2'd2, 5'd0, 1'b0);
    for (int i = 0; i < 29; i++) begin
      tick(1);
      chk("handback_quiet", 32'(step_pulse), 32'd0);
    end
    tick(1);
    chk_all("handback_pulse", 3'b010, 2'd2, 5'd1, 1'b1);
    btn1 = 1'b1;
    tick(23);
    chk_all("b_rel_idle", 3'b000, 2'd0, 5'd0, 1'b0);

    // PAT_C: wrap at 12, then reset mid-run at step 7
    btn2 = 1'b0;
    tick(22);
    chk("c_db", 32'(btn_db), 32'b100);
    tick(1);
    chk_all("c_mode", 3'b100, 2'd3, 5'd0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick(30);
      chk($sformatf("c_step%0d", k), 32'(step), 32'(k % 12));
      chk($sformatf("c_pulse%0d", k), 32'(step_pulse), 32'd1);
    end
    tick(30 * 7);
    chk_all("c_step7", 3'b100, 2'd3, 5'd7, 1'b1);
    swch1 = 1'b1;
    tick(1);
    chk_all("c_reset", 3'b000, 2'd0, 5'd0, 1'b0);
    swch1 = 1'b0;
    tick(21);
    chk_all("c_redebounce21", 3'b000, 2'd0, 5'd0, 1'b0);
    tick(1);
    chk("c_redebounce22", 32'(btn_db), 32'b100);
    tick(1);
    chk_all("c_mode_back", 3'b100, 2'd3, 5'd0, 1'b0);

    // Release everything: IDLE, no more pulses
    tick(10);
    btn2 = 1'b1;
    tick(22);
    chk("idle_db", 32'(btn_db), 32'd0);
    chk("idle_mode_pre", 32'(mode), 32'd3);
    tick(1);
    chk_all("idle_final", 3'b000, 2'd0, 5'd0, 1'b0);
    for (int i = 0; i < 70; i++) begin
      tick(1);
      chk("idle_nopulse", 32'({step_pulse, step}), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/anim_step_ctrl.md
# anim_step_ctrl

Front-end control stage for the board's segment-animation display logic. It conditions the three raw active-low push buttons (synchronise, debounce), resolves them into one animation mode by fixed priority, and runs the step timebase. Its outputs are `mode`, `step` and a one-cycle `step_pulse`, which the downstream pattern/segment stage consumes directly as its pattern select and pattern index.

## Interface
Parameters:
- `CLOCK_MHZ`, 50: clock frequency in MHz.
- `US_PER_MS`, 1000: microsecond ticks per millisecond. Reduced only in simulation.
- `DEBOUNCE_MS`, 10: time a button level must be stable before it is accepted.
- `STEP_MS`, 500: animation step period.
- Derived localparams:
  - `MS_CYC = CLOCK_MHZ*US_PER_MS`
  - `DEB_CYC = DEBOUNCE_MS*MS_CYC`
  - `STEP_CYC = STEP_MS*MS_CYC`

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `swch1`, in, 1: reset. Synchronous, active-high.
- `btn0`, `btn1`, `btn2`, in, 1 each: raw buttons, asynchronous, active-low (0 = pressed).
- `btn_db`, out, 3: debounced pressed flags, active-high; bit i corresponds to `btni`.
- `mode`, out, 2: 0 = IDLE, 1 = PAT_A (btn0), 2 = PAT_B (btn1), 3 = PAT_C (btn2).
- `step`, out, 5: current pattern index.
- `step_pulse`, out, 1: high for exactly one cycle when `step` takes a new value.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser. The flops reset to 1 (the released level).
- **Debouncer (per button):**
  - The cycle counter clears whenever the synchronised pressed level equals `btn_db[i]`.
  - Otherwise it increments each cycle.
  - When the counter reaches `DEB_CYC-1`, `btn_db[i]` toggles and the counter clears.
  - Any bounce restarts the count.
- **Mode resolution:** `next_mode` = 1 if `btn_db[0]`, else 2 if `btn_db[1]`, else 3 if `btn_db[2]`, else 0. `mode` is registered from `next_mode`.
- **Pattern lengths:** LEN(1)=20, LEN(2)=8, LEN(3)=12.
- **Mode change** (`next_mode != mode`): on that edge `step` <= 0, the phase counter <= 0, and `step_pulse` <= 0.
- **Non-IDLE, mode unchanged:**
  - The phase counter increments each cycle.
  - At `phase == STEP_CYC-1`: phase <= 0, `step` <= (`step == LEN-1`) ? 0 : `step+1`, and `step_pulse` <= 1.
  - `step_pulse` is 0 in every other cycle.
- **IDLE:** phase, `step` and `step_pulse` are held at 0.
- **Reset values** (applied at the next edge while `swch1`=1, from any state): `btn_db`=0, `mode`=0, `step`=0, `step_pulse`=0, all counters 0. Buttons held through reset are re-debounced from scratch.

## Timing
- **Press latency:** raw edge to `btn_db` rising = `DEB_CYC+2` cycles. `mode` updates 1 cycle later, at `DEB_CYC+3`. Release latency is identical.
- **First step:** first `step_pulse` comes `STEP_CYC` cycles after the edge that changed `mode`. Subsequent pulses follow every `STEP_CYC` cycles.
- **Pulse alignment:** `step_pulse` is high in the same cycle that the new `step` is first visible.
- **Simultaneous presses:** the lower index wins. A lower-priority press under a held higher-priority one causes no mode change, no step reset, and no pulse disturbance.
- **Priority hand-back:** releasing the winning button while another is held switches to that button's mode with `step`=0.
- **Counter widths:** phase and debounce counters are sized with `$clog2` of `STEP_CYC` and `DEB_CYC` respectively. `step` never exceeds 19.

## Structure
- **Shared package `anim_pkg`:** mode encodings (`MODE_IDLE`, `MODE_A`, `MODE_B`, `MODE_C`), `LEN_A`=20, `LEN_B`=8, `LEN_C`=12, and `STEP_W`=5. These are shared with the downstream pattern stage.
- **Sub-module `btn_debounce`:** synchroniser plus debounce counter, parameter `DEB_CYC`. Instantiated three times.
- **Top level:** mode resolution and the step timebase.

## Test plan
Bench parameters: `CLOCK_MHZ`=2, `US_PER_MS`=5, `DEBOUNCE_MS`=2, `STEP_MS`=3, giving `DEB_CYC`=20 and `STEP_CYC`=30.

- **Reset:** assert `swch1` with all buttons high -> `btn_db`=0, `mode`=0, `step`=0, `step_pulse`=0 for all cycles.
- **PAT_A run:** drive `btn0` low and hold -> `btn_db[0]`=1 at edge+22, `mode`=1 at edge+23. Pulses every 30 cycles; `step` runs 1..19, then 0 on the 20th pulse.
- **Bounce rejection:** `btn1` low 15 cycles, high 3 cycles, then low -> `btn_db[1]` rises 22 cycles after the final falling edge, never earlier.
- **Priority:** hold `btn1` until `step`=5 (`mode`=2), then press `btn0` -> `mode`=1, `step`=0. Release `btn0` -> `mode`=2, `step`=0, next pulse 30 cycles later.
- **PAT_C with mid-run reset:** hold `btn2` -> `step` wraps 11->0. Pulse `swch1` at `step`=7 -> all outputs 0 next cycle; after release `mode`=3 returns 23 cycles later.
- **Release to IDLE:** release all buttons -> `mode`=0 23 cycles after release, `step`=0, no further `step_pulse`.
